sram_synaptic_arbiter: RTL

Single-port access controller for the synaptic weight SRAM. It shares the one SRAM port between three requesters: the configuration host (read/write), the inference engine (read-only weight fetch), and the learning engine (atomic read-modify-write). It sits directly in front of the synaptic SRAM macro. It drives CS/WE/A/D and forwards Q, which follows the SRAM's 1-cycle synchronous-read, hold-when-deselected behaviour.

---
 rtl/sram_synaptic_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sram_synaptic_arbiter.sv
// Single-port arbiter for the synaptic weight SRAM: host R/W, inference reads, learning RMW.
// Define SYN_ARB_RR_EN for round-robin between inference and learning reads (default: inference first).
module sram_synaptic_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CK,
    input  logic                  RST_N,
    input  logic                  CFG_REQ,
    input  logic                  CFG_WE,
    input  logic [ADDR_WIDTH-1:0] CFG_ADDR,
    input  logic [DATA_WIDTH-1:0] CFG_WDATA,
    output logic                  CFG_GNT,
    output logic                  CFG_RVALID,
    input  logic                  INF_REQ,
    input  logic [ADDR_WIDTH-1:0] INF_ADDR,
    output logic                  INF_GNT,
    output logic                  INF_RVALID,
    input  logic                  LRN_REQ,
    input  logic [ADDR_WIDTH-1:0] LRN_ADDR,
    output logic                  LRN_GNT,
    output logic                  LRN_RVALID,
    input  logic                  LRN_WVALID,
    input  logic [DATA_WIDTH-1:0] LRN_WDATA,
    output logic                  LRN_WDONE,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  SRAM_CS,
    output logic                  SRAM_WE,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q,
    output logic                  BUSY
);

    typedef enum logic [1:0] {IDLE, RD, MOD, WB_PEND} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] lock_addr_q, lock_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cfg_rvalid_q, inf_rvalid_q;

    logic busy, cfg_stall, cfg_gnt, wb_ready, wdone, rd_free, lrn_elig;
    logic inf_gnt, lrn_gnt;

    assign busy      = (state_q != IDLE);
    // Only host writes to the word under modification must wait; reads may see the old value.
    assign cfg_stall = busy && CFG_WE && (CFG_ADDR == lock_addr_q);
    assign cfg_gnt   = CFG_REQ && !cfg_stall;
    assign wb_ready  = (state_q == WB_PEND) || ((state_q == MOD) && LRN_WVALID);
    assign wdone     = wb_ready && !cfg_gnt;
    assign rd_free   = !cfg_gnt && !wdone;
    assign lrn_elig  = LRN_REQ && !busy;

`ifdef SYN_ARB_RR_EN
    logic rr_q, rr_d;  // 1: learning has the next turn

    always_comb begin
        inf_gnt = rd_free && INF_REQ && !(lrn_elig && rr_q);
        lrn_gnt = rd_free && lrn_elig && (!INF_REQ || rr_q);
        rr_d    = rr_q;
        if (lrn_gnt)
            rr_d = 1'b0;
        else if (inf_gnt && !busy)
            rr_d = 1'b1;
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    assign inf_gnt = rd_free && INF_REQ;
    assign lrn_gnt = rd_free && lrn_elig && !INF_REQ;
`endif

    always_comb begin
        SRAM_CS = cfg_gnt || inf_gnt || lrn_gnt || wdone;
        SRAM_WE = 1'b0;
        SRAM_A  = '0;
        SRAM_D  = '0;
        if (cfg_gnt) begin
            SRAM_WE = CFG_WE;
            SRAM_A  = CFG_ADDR;
            SRAM_D  = CFG_WE ? CFG_WDATA : '0;
        end else if (wdone) begin
            SRAM_WE = 1'b1;
            SRAM_A  = lock_addr_q;
            SRAM_D  = (state_q == MOD) ? LRN_WDATA : wdata_q;
        end else if (inf_gnt) begin
            SRAM_A  = INF_ADDR;
        end else if (lrn_gnt) begin
            SRAM_A  = LRN_ADDR;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_addr_d = lock_addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: if (lrn_gnt) begin
                state_d     = RD;
                lock_addr_d = LRN_ADDR;
            end
            RD:   state_d = MOD;
            MOD:  if (LRN_WVALID) begin
                wdata_d = LRN_WDATA;
                state_d = wdone ? IDLE : WB_PEND;
            end
            WB_PEND: if (wdone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            lock_addr_q  <= '0;
            wdata_q      <= '0;
            cfg_rvalid_q <= 1'b0;
            inf_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_addr_q  <= lock_addr_d;
            wdata_q      <= wdata_d;
            cfg_rvalid_q <= cfg_gnt && !CFG_WE;
            inf_rvalid_q <= inf_gnt;
        end
    end

    assign CFG_GNT    = cfg_gnt;
    assign INF_GNT    = inf_gnt;
    assign LRN_GNT    = lrn_gnt;
    assign LRN_WDONE  = wdone;
    assign CFG_RVALID = cfg_rvalid_q;
    assign INF_RVALID = inf_rvalid_q;
    assign LRN_RVALID = (state_q == RD);
    assign RDATA      = SRAM_Q;
    assign BUSY       = busy;

endmodule
